// File: rtl/pixel_stream_generator.sv
// Purpose: VGA-style raster timing generator that overlays one solid rectangle on a black field.
// Latency: all outputs are registered one clock after the h/v counter values they decode.
// Backpressure: none; enable=0 freezes the raster and every output, while cfg_load is still captured as pending.
//
// Ports:
//   clock, resetn           - system clock (rising edge) and asynchronous active-low reset
//   enable                  - 1 advances the raster by one pixel per clock
//   cfg_load, obj_*         - rectangle update request, adopted only at the frame-wrap clock
//   pixel_out, hsync, vsync - registered video outputs
//   x_curr, y_curr, active  - registered raster position and visible-area flag
//   frame_count             - completed frames (wraps at 16 bits)
module pixel_stream_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    input  logic        cfg_load,
    input  logic [10:0] obj_x,
    input  logic [10:0] obj_y,
    input  logic [10:0] obj_w,
    input  logic [10:0] obj_h,
    input  logic [29:0] obj_color,
    output logic [29:0] pixel_out,
    output logic        hsync,
    output logic        vsync,
    output logic [10:0] x_curr,
    output logic [10:0] y_curr,
    output logic        active,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        REG_ACTIVE = 2'd0,
        REG_FP     = 2'd1,
        REG_SYNC   = 2'd2,
        REG_BP     = 2'd3
    } region_t;

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        pending;

    // Rectangle actually used for drawing; only changes at the frame wrap.
    logic [10:0] shadow_x;
    logic [10:0] shadow_y;
    logic [10:0] shadow_w;
    logic [10:0] shadow_h;
    logic [29:0] shadow_color;

    function automatic region_t decode(input logic [10:0] c, input int n_act,
                                       input int n_fp, input int n_sync);
        if (c < 11'(n_act))
            return REG_ACTIVE;
        else if (c < 11'(n_act + n_fp))
            return REG_FP;
        else if (c < 11'(n_act + n_fp + n_sync))
            return REG_SYNC;
        else
            return REG_BP;
    endfunction

    region_t h_reg;
    region_t v_reg;
    logic    h_last;
    logic    v_last;
    logic    frame_wrap;
    logic    vis;
    logic    in_rect;
    logic [11:0] x_end;
    logic [11:0] y_end;

    always_comb begin
        h_reg      = decode(h_cnt, H_ACTIVE, H_FP, H_SYNC);
        v_reg      = decode(v_cnt, V_ACTIVE, V_FP, V_SYNC);
        h_last     = (h_cnt == 11'(H_TOTAL - 1));
        v_last     = (v_cnt == 11'(V_TOTAL - 1));
        frame_wrap = enable && h_last && v_last;
        vis        = (h_reg == REG_ACTIVE) && (v_reg == REG_ACTIVE);
        // 12-bit exclusive bounds: x+w cannot wrap back into the visible area.
        x_end      = {1'b0, shadow_x} + {1'b0, shadow_w};
        y_end      = {1'b0, shadow_y} + {1'b0, shadow_h};
        // A zero width/height gives end == start, so the half-open range is empty.
        in_rect    = (h_cnt >= shadow_x) && ({1'b0, h_cnt} < x_end) &&
                     (v_cnt >= shadow_y) && ({1'b0, v_cnt} < y_end);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            pending      <= 1'b0;
            shadow_x     <= '0;
            shadow_y     <= '0;
            shadow_w     <= '0;
            shadow_h     <= '0;
            shadow_color <= '0;
            pixel_out    <= '0;
            hsync        <= 1'b0;
            vsync        <= 1'b0;
            x_curr       <= '0;
            y_curr       <= '0;
            active       <= 1'b0;
            frame_count  <= '0;
        end else begin
            if (enable) begin
                h_cnt <= h_last ? 11'd0 : h_cnt + 11'd1;
                if (h_last)
                    v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;

                x_curr    <= h_cnt;
                y_curr    <= v_cnt;
                hsync     <= (h_reg == REG_SYNC);
                vsync     <= (v_reg == REG_SYNC);
                active    <= vis;
                pixel_out <= (vis && in_rect) ? shadow_color : 30'd0;

                if (frame_wrap)
                    frame_count <= frame_count + 16'd1;
            end

            // A load requested on the wrap clock itself is taken immediately.
            if (frame_wrap && (pending || cfg_load)) begin
                shadow_x     <= obj_x;
                shadow_y     <= obj_y;
                shadow_w     <= obj_w;
                shadow_h     <= obj_h;
                shadow_color <= obj_color;
                pending      <= 1'b0;
            end else if (cfg_load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_generator.sv
module tb_pixel_stream_generator;

    // Reduced raster so whole frames fit in a short run.
    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 12, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;   // 24
    localparam int VT = VA + VFP + VSY + VBP;   // 19
    localparam int FRAME = HT * VT;             // 456

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_load = 1'b0;
    logic [10:0] obj_x = '0, obj_y = '0, obj_w = '0, obj_h = '0;
    logic [29:0] obj_color = '0;
    logic [29:0] pixel_out;
    logic        hsync, vsync, active;
    logic [10:0] x_curr, y_curr;
    logic [15:0] frame_count;

    pixel_stream_generator #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .cfg_load(cfg_load),
        .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
        .obj_color(obj_color), .pixel_out(pixel_out), .hsync(hsync),
        .vsync(vsync), .x_curr(x_curr), .y_curr(y_curr), .active(active),
        .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          x;
        int          y;
        logic        hs;
        logic        vs;
        logic        act;
        logic [29:0] pix;
        logic [15:0] fc;
    } exp_t;

    typedef struct {
        int          x, y, w, h;
        logic [29:0] col;
        int          cnt;
    } vec_t;

    exp_t q[$];
    exp_t last_e;

    // Reference model state
    int          mh, mv;
    logic        mpend;
    int          sx, sy, sw, sh;
    logic [29:0] scol;
    logic [15:0] mfc;

    int total = 0;
    int bad = 0;
    int cnt_pix, cnt_hs, cnt_vs, first_hs_x;
    logic prev_hs;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] req_v);
        total++;
        if (act_v !== req_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (x=%0d y=%0d)", name, act_v, req_v, x_curr, y_curr);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mpend = 1'b0;
        sx = 0; sy = 0; sw = 0; sh = 0; scol = '0; mfc = '0;
        last_e = '{x: 0, y: 0, hs: 1'b0, vs: 1'b0, act: 1'b0, pix: 30'd0, fc: 16'd0};
        q.delete();
    endtask

    // Push the expected post-edge outputs, clock once, pop and compare.
    task automatic step();
        exp_t e;
        logic wrap;
        if (enable) begin
            e.x   = mh;
            e.y   = mv;
            e.hs  = (mh >= HA + HFP) && (mh < HA + HFP + HSY);
            e.vs  = (mv >= VA + VFP) && (mv < VA + VFP + VSY);
            e.act = (mh < HA) && (mv < VA);
            e.pix = (e.act && mh >= sx && mh < sx + sw && mv >= sy && mv < sy + sh) ? scol : 30'd0;
            wrap  = (mh == HT - 1) && (mv == VT - 1);
            if (wrap) mfc = mfc + 16'd1;
            e.fc  = mfc;
            if (wrap && (mpend || cfg_load)) begin
                sx = int'(obj_x); sy = int'(obj_y); sw = int'(obj_w); sh = int'(obj_h);
                scol = obj_color; mpend = 1'b0;
            end else if (cfg_load) begin
                mpend = 1'b1;
            end
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end else begin
            e = last_e;
            if (cfg_load) mpend = 1'b1;
        end
        last_e = e;
        q.push_back(e);

        @(posedge clock);
        #1;
        e = q.pop_front();
        chk("x_curr", 32'(x_curr), 32'(e.x));
        chk("y_curr", 32'(y_curr), 32'(e.y));
        chk("hsync", 32'(hsync), 32'(e.hs));
        chk("vsync", 32'(vsync), 32'(e.vs));
        chk("active", 32'(active), 32'(e.act));
        chk("pixel_out", 32'(pixel_out), 32'(e.pix));
        chk("frame_count", 32'(frame_count), 32'(e.fc));
        if (active && pixel_out != 30'd0) cnt_pix++;
        if (!active && pixel_out != 30'd0) chk("blank_pixel", 32'(pixel_out), 32'd0);
        if (hsync) cnt_hs++;
        if (vsync) cnt_vs++;
        if (hsync && !prev_hs && first_hs_x < 0) first_hs_x = int'(x_curr);
        prev_hs = hsync;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_frame_start();
        int guard = 0;
        while (!(mh == 0 && mv == 0) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        if (guard >= 2 * FRAME) chk("frame_start_timeout", 32'(guard), 32'd0);
    endtask

    task automatic set_obj(input vec_t v);
        obj_x = 11'(v.x); obj_y = 11'(v.y); obj_w = 11'(v.w); obj_h = 11'(v.h);
        obj_color = v.col;
    endtask

    vec_t tbl[6];
    vec_t v;
    int   guard;

    initial begin
        tbl[0] = '{x: 4,  y: 3,  w: 5,    h: 2,    col: 30'h3FF00000, cnt: 10};
        tbl[1] = '{x: 14, y: 10, w: 10,   h: 10,   col: 30'h000FFC00, cnt: 4};
        tbl[2] = '{x: 2,  y: 2,  w: 0,    h: 5,    col: 30'h000003FF, cnt: 0};
        tbl[3] = '{x: 2,  y: 2,  w: 5,    h: 0,    col: 30'h000003FF, cnt: 0};
        tbl[4] = '{x: 1,  y: 1,  w: 2047, h: 2047, col: 30'h12345678, cnt: 165};
        tbl[5] = '{x: 0,  y: 0,  w: 16,   h: 12,   col: 30'h3FFFFFFF, cnt: 192};

        model_reset();
        prev_hs = 1'b0;
        #12;
        chk("rst_x", 32'(x_curr), 32'd0);
        chk("rst_y", 32'(y_curr), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_pixel", 32'(pixel_out), 32'd0);
        chk("rst_sync", 32'({hsync, vsync}), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);

        // Release reset away from the clock edge, then free-run one frame.
        @(posedge clock); #1;
        resetn = 1'b1;
        enable = 1'b1;
        cnt_hs = 0; cnt_vs = 0; cnt_pix = 0; first_hs_x = -1;
        step();
        chk("first_x", 32'(x_curr), 32'd0);
        chk("first_y", 32'(y_curr), 32'd0);
        chk("first_active", 32'(active), 32'd1);
        run(FRAME - 2);
        chk("fc_before_wrap", 32'(frame_count), 32'd0);
        step();
        chk("fc_after_frame", 32'(frame_count), 32'd1);
        chk("hsync_clocks", 32'(cnt_hs), 32'(HSY * VT));
        chk("vsync_clocks", 32'(cnt_vs), 32'(VSY * HT));
        chk("hsync_start_x", 32'(first_hs_x), 32'(HA + HFP));
        chk("pix_after_reset", 32'(cnt_pix), 32'd0);

        // Table: load mid-frame, then count coloured pixels in the next full frame.
        for (int i = 0; i < 6; i++) begin
            run(100);
            set_obj(tbl[i]);
            cfg_load = 1'b1;
            cnt_pix = 0;
            step();
            cfg_load = 1'b0;
            run_to_frame_start();
            if (i == 0) chk("load_frame_unchanged", 32'(cnt_pix), 32'd0);
            cnt_pix = 0;
            run(FRAME);
            chk($sformatf("rect_count[%0d]", i), 32'(cnt_pix), 32'(tbl[i].cnt));
        end

        // cfg_load pulsed exactly on the wrap clock takes effect next frame.
        guard = 0;
        while (!(mh == HT - 1 && mv == VT - 1) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        set_obj(tbl[0]);
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        cnt_pix = 0;
        run(FRAME);
        chk("wrap_load_count", 32'(cnt_pix), 32'(tbl[0].cnt));

        // Freeze at x_curr=10 for 10 clocks; cfg_load during freeze stays pending.
        guard = 0;
        while (!(mh == 11 && mv == 0) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        chk("freeze_start_x", 32'(x_curr), 32'd10);
        enable = 1'b0;
        v = '{x: 0, y: 0, w: 1, h: 1, col: 30'h00000001, cnt: 1};
        set_obj(v);
        for (int i = 0; i < 10; i++) begin
            cfg_load = (i == 3);
            step();
        end
        cfg_load = 1'b0;
        chk("frozen_x", 32'(x_curr), 32'd10);
        enable = 1'b1;
        step();
        chk("resume_x", 32'(x_curr), 32'd11);
        run_to_frame_start();
        cnt_pix = 0;
        run(FRAME);
        chk("pending_load_count", 32'(cnt_pix), 32'd1);

        // Mid-frame reset: outputs clear without a clock, then restart at (0,0).
        run(50);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("midrst_x", 32'(x_curr), 32'd0);
        chk("midrst_y", 32'(y_curr), 32'd0);
        chk("midrst_active", 32'(active), 32'd0);
        chk("midrst_pixel", 32'(pixel_out), 32'd0);
        chk("midrst_fc", 32'(frame_count), 32'd0);
        @(posedge clock); #1;
        chk("midrst_hold_x", 32'(x_curr), 32'd0);
        resetn = 1'b1;
        step();
        chk("restart_x", 32'(x_curr), 32'd0);
        chk("restart_y", 32'(y_curr), 32'd0);
        chk("restart_active", 32'(active), 32'd1);
        run(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pixel_stream_generator.md
PIXEL_STREAM_GENERATOR -- requirements
Module: pixel_stream_generator

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
 H_ACTIVE 640 visible pixels per line
 H_FP 16 horizontal front porch clocks
 H_SYNC 96 hsync pulse clocks
 H_BP 48 horizontal back porch clocks
 V_ACTIVE 480 visible lines
 V_FP 10 vertical front porch lines
 V_SYNC 2 vsync pulse lines
 V_BP 33 vertical back porch lines
REQ-002 SHALL have ports (name direction width meaning), one per line:
 clock input 1 single system clock, all state on rising edge
 resetn input 1 asynchronous active-low reset
 enable input 1 1 = raster advances, 0 = raster frozen
 cfg_load input 1 request to adopt obj_* inputs at next frame boundary
 obj_x input 11 rectangle left column
 obj_y input 11 rectangle top row
 obj_w input 11 rectangle width in pixels
 obj_h input 11 rectangle height in lines
 obj_color input 30 rectangle colour {R10,G10,B10}
 pixel_out output 30 pixel for (x_curr, y_curr)
 hsync output 1 active-high line sync
 vsync output 1 active-high frame sync
 x_curr output 11 current column
 y_curr output 11 current row
 active output 1 1 inside visible area
 frame_count output 16 completed-frame counter

Function
REQ-003 SHALL keep h_cnt in 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800) and v_cnt in 0..V_TOTAL-1 (V_TOTAL = 525).
REQ-004 SHALL, when enable=1, increment h_cnt each clock; at h_cnt=H_TOTAL-1, wrap h_cnt to 0 and increment v_cnt; at v_cnt=V_TOTAL-1 with h_cnt wrap, wrap v_cnt to 0.
REQ-005 SHALL, when enable=0, hold h_cnt, v_cnt, all outputs and the pending flag; cfg_load still sets pending.
REQ-006 SHALL decode horizontal state ACTIVE (h<640), FP (640..655), SYNC (656..751), BP (752..799), and the same four vertical states (active <480, FP 480..489, SYNC 490..491, BP 492..524).
REQ-007 SHALL assert hsync only in horizontal SYNC and vsync only in vertical SYNC (vsync spans full lines, including blanking).
REQ-008 SHALL register all outputs one clock after the counter values they decode; x_curr, y_curr, hsync, vsync, active and pixel_out are mutually cycle-aligned.
REQ-009 SHALL drive x_curr=h_cnt and y_curr=v_cnt, including during blanking.
REQ-010 SHALL drive pixel_out=shadow colour when active=1 and shadow_x <= x < shadow_x+shadow_w and shadow_y <= y < shadow_y+shadow_h, otherwise 30'd0 (including all blanking).
REQ-011 SHALL compute rectangle right/bottom bounds at 12 bits so that the sum never wraps; clip silently at the visible edge.
REQ-012 SHALL emit no rectangle pixels when shadow_w=0 or shadow_h=0.
REQ-013 SHALL set a pending flag on any clock with cfg_load=1.
REQ-014 SHALL, on the frame-wrap clock (h_cnt=799, v_cnt=524, enable=1) with pending set or cfg_load=1, copy obj_* into shadow registers and clear pending; shadow values never change mid-frame.
REQ-015 SHALL increment frame_count on each frame-wrap clock, 65535 wrapping to 0.

Reset
REQ-016 SHALL, while resetn=0, asynchronously clear h_cnt, v_cnt, pending, frame_count, all shadow registers and every output to 0.
REQ-017 SHALL, after resetn deasserts with enable=1, present x_curr=0, y_curr=0, active=1 one clock after the first counted edge; assertion mid-frame aborts the frame, with no partial frame_count increment.

Verification
REQ-018 Free-run one frame: hsync high for exactly 96 clocks per line starting at x_curr=656; vsync high for exactly 1600 clocks at y_curr 490-491; frame_count 0->1 after 420000 clocks.
REQ-019 Load obj=(200,250,50,30, 30'h3FF00000) mid-frame: current frame pixel_out all 0; next frame pixel_out=30'h3FF00000 exactly for x 200..249, y 250..279 (1500 pixels).
REQ-020 Clip: obj=(620,470,100,100): coloured pixels only for x 620..639, y 470..479 (200 pixels); none in blanking.
REQ-021 obj_w=0: zero coloured pixels per frame; cfg_load pulsed on the wrap clock: new values take effect the immediately following frame.
REQ-022 enable=0 for 10 clocks at x_curr=300: all outputs frozen, then resume at x_curr=301; resetn pulsed low mid-frame: outputs 0 immediately, frame_count 0, restart at (0,0).
